writeback_unit: RTL and testbench

Write-back stage for the LEGv8 pipeline; the producer end of the register-file write port (regWrite / writeRegister / writeData) consumed by the operand-prep stage. Accepts completed results from execute/memory through a valid/ready handshake, selects ALU or D-cache data, buffers them in a small in-order FIFO and retires at most one register write per clock. Exposes pending-write flags so operand prep can detect read-after-write hazards on its two source registers.

---
 rtl/writeback_unit.sv | 106 ++++++++++
 tb/tb_writeback_unit.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/writeback_unit.sv
// LEGv8 write-back stage: buffers completed results in an in-order FIFO
// and retires at most one register-file write per clock.
module writeback_unit #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_reg_write,
  input  logic             in_mem_to_reg,
  input  logic [4:0]       in_dest,
  input  logic [31:0]      alu_result,
  input  logic [31:0]      mem_read_data,
  input  logic             stall_wb,
  output logic             regWrite,
  output logic [4:0]       writeRegister,
  output logic [31:0]      writeData,
  input  logic [4:0]       query_reg1,
  input  logic [4:0]       query_reg2,
  output logic             pending1,
  output logic             pending2,
  output logic [CNT_W-1:0] wb_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [4:0] XZR = 5'd31;

  typedef struct packed {
    logic [4:0]  dest;
    logic [31:0] data;
  } wb_entry_t;

  wb_entry_t        mem [DEPTH];
  wb_entry_t        entry;
  wb_entry_t        head;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [AW:0]      count;
  logic             push;
  logic             pop;
  logic [DEPTH-1:0] live;

  assign in_ready = count < (AW+1)'(DEPTH);
  assign push     = in_valid && in_ready
                 && in_reg_write && (in_dest != XZR);
  assign pop      = (count != '0) && !stall_wb;
  assign entry    = '{dest: in_dest,
                      data: in_mem_to_reg ? mem_read_data
                                          : alu_result};
  assign head     = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= entry;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      count         <= '0;
      regWrite      <= 1'b0;
      writeRegister <= '0;
      writeData     <= '0;
      wb_count      <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case (1'b1)
        (push && !pop): count <= count + 1'b1;
        (pop && !push): count <= count - 1'b1;
        default:        ;
      endcase
      if (pop) begin
        regWrite      <= 1'b1;
        writeRegister <= head.dest;
        writeData     <= head.data;
        wb_count      <= wb_count + 1'b1;
      end else begin
        regWrite  <= 1'b0;
        writeData <= '0;
      end
    end
  end

  // slot i holds a live entry when its distance from head is below count
  always_comb begin
    live = '0;
    for (int i = 0; i < DEPTH; i++) begin
      live[i] = {1'b0, AW'(i) - rd_ptr} < count;
    end
  end

  always_comb begin
    pending1 = regWrite && (writeRegister == query_reg1);
    pending2 = regWrite && (writeRegister == query_reg2);
    for (int i = 0; i < DEPTH; i++) begin
      if (live[i] && mem[i].dest == query_reg1) pending1 = 1'b1;
      if (live[i] && mem[i].dest == query_reg2) pending2 = 1'b1;
    end
    if (query_reg1 == XZR) pending1 = 1'b0;
    if (query_reg2 == XZR) pending2 = 1'b0;
  end

endmodule

// File: tb/tb_writeback_unit.sv
// Directed bench for writeback_unit with a scoreboard of expected
// register writes popped on every regWrite pulse.
module tb_writeback_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_reg_write = 1'b1;
  logic        in_mem_to_reg = 1'b0;
  logic [4:0]  in_dest = '0;
  logic [31:0] alu_result = '0;
  logic [31:0] mem_read_data = '0;
  logic        stall_wb = 1'b0;
  logic        regWrite;
  logic [4:0]  writeRegister;
  logic [31:0] writeData;
  logic [4:0]  query_reg1 = 5'd5;
  logic [4:0]  query_reg2 = 5'd31;
  logic        pending1;
  logic        pending2;
  logic [15:0] wb_count;

  int checks = 0;
  int errors = 0;
  logic [36:0] sb[$];

  writeback_unit #(.DEPTH(4), .CNT_W(16)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_reg_write(in_reg_write), .in_mem_to_reg(in_mem_to_reg),
    .in_dest(in_dest), .alu_result(alu_result),
    .mem_read_data(mem_read_data), .stall_wb(stall_wb),
    .regWrite(regWrite), .writeRegister(writeRegister),
    .writeData(writeData), .query_reg1(query_reg1),
    .query_reg2(query_reg2), .pending1(pending1),
    .pending2(pending2), .wb_count(wb_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // every pulse must match the oldest outstanding expected write
  always @(negedge clock) begin
    if (!reset && regWrite) begin
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("FAIL extra_pulse: observed dest %0d data %0h expected none",
               writeRegister, writeData);
      end
      if (sb.size() != 0) begin
        logic [36:0] e;
        e = sb.pop_front();
        chk("wb_dest", 32'(writeRegister), 32'(e[36:32]));
        chk("wb_data", writeData, e[31:0]);
      end
    end
  end

  // called at posedge+1; returns at posedge+1 after the transfer edge
  task automatic send(input logic [4:0] d, input logic m2r,
                      input logic [31:0] alu, input logic [31:0] mem,
                      input logic rw);
    int n = 0;
    in_dest = d; in_mem_to_reg = m2r;
    alu_result = alu; mem_read_data = mem;
    in_reg_write = rw; in_valid = 1'b1;
    while (!in_ready && n < 100) begin
      @(posedge clock); #1; n++;
    end
    if (n >= 100) chk("ready_timeout", 32'(in_ready), 32'd1);
    if (rw && d != 5'd31) sb.push_back({d, m2r ? mem : alu});
    @(posedge clock); #1;
    in_valid = 1'b0; in_reg_write = 1'b1;
  endtask

  task automatic drain_wait();
    int n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(negedge clock); #1; n++;
    end
    chk("drain_left", sb.size(), 32'd0);
    @(posedge clock); #1;
  endtask

  initial begin
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    chk("rst_regWrite", 32'(regWrite), 32'd0);
    chk("rst_wreg", 32'(writeRegister), 32'd0);
    chk("rst_wdata", writeData, 32'd0);
    chk("rst_count", 32'(wb_count), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_pend1", 32'(pending1), 32'd0);

    send(5'd5, 1'b0, 32'h0000_002A, 32'h0, 1'b1);
    chk("t1_pend_cap", 32'(pending1), 32'd1);
    chk("t1_latency", 32'(regWrite), 32'd0);
    @(posedge clock); #1;
    chk("t1_pulse", 32'(regWrite), 32'd1);
    chk("t1_wreg", 32'(writeRegister), 32'd5);
    chk("t1_wdata", writeData, 32'd42);
    chk("t1_pend_pulse", 32'(pending1), 32'd1);
    @(posedge clock); #1;
    chk("t1_pulse_end", 32'(regWrite), 32'd0);
    chk("t1_wreg_hold", 32'(writeRegister), 32'd5);
    chk("t1_wdata_clr", writeData, 32'd0);
    chk("t1_pend_clr", 32'(pending1), 32'd0);
    chk("t1_count", 32'(wb_count), 32'd1);

    send(5'd9, 1'b1, 32'h1, 32'hDEAD_BEEF, 1'b1);
    drain_wait();
    chk("t2_count", 32'(wb_count), 32'd2);

    query_reg1 = 5'd31; query_reg2 = 5'd7;
    send(5'd31, 1'b0, 32'h77, 32'h0, 1'b1);
    chk("t3_pend_xzr", 32'(pending1), 32'd0);
    send(5'd7, 1'b0, 32'h88, 32'h0, 1'b0);
    chk("t3_pend_norw", 32'(pending2), 32'd0);
    repeat (3) @(posedge clock); #1;
    chk("t3_count", 32'(wb_count), 32'd2);

    query_reg1 = 5'd3; query_reg2 = 5'd5;
    stall_wb = 1'b1;
    for (int i = 1; i <= 4; i++)
      send(5'(i), 1'b0, 32'(100 + i), 32'h0, 1'b1);
    chk("t4_full", 32'(in_ready), 32'd0);
    chk("t4_pend_q", 32'(pending1), 32'd1);
    chk("t4_pend_none", 32'(pending2), 32'd0);
    @(posedge clock); #1;
    chk("t4_stalled", 32'(regWrite), 32'd0);
    in_dest = 5'd5; alu_result = 32'd105; in_valid = 1'b1;
    stall_wb = 1'b0;
    sb.push_back({5'd5, 32'd105});
    for (int k = 1; k <= 4; k++) begin
      @(posedge clock); #1;
      if (k == 2) in_valid = 1'b0;
      chk("t4_consec", 32'(regWrite), 32'd1);
      chk("t4_order", 32'(writeRegister), 32'(k));
    end
    drain_wait();
    chk("t4_count", 32'(wb_count), 32'd7);

    stall_wb = 1'b1;
    send(5'd10, 1'b0, 32'h1010, 32'h0, 1'b1);
    send(5'd11, 1'b1, 32'h0, 32'h1111, 1'b1);
    stall_wb = 1'b0;
    for (int i = 0; i < 8; i++) begin
      send(5'(12 + i), 1'b0, 32'(32'h2000 + i), 32'h0, 1'b1);
      chk("t5_pop", 32'(regWrite), 32'd1);
      chk("t5_ready", 32'(in_ready), 32'd1);
    end
    drain_wait();
    chk("t5_count", 32'(wb_count), 32'd17);

    stall_wb = 1'b1;
    for (int i = 0; i < 3; i++)
      send(5'(20 + i), 1'b0, 32'(32'h3000 + i), 32'h0, 1'b1);
    stall_wb = 1'b0;
    @(posedge clock); #1;
    chk("t6_pulse", 32'(regWrite), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("t6_async_rw", 32'(regWrite), 32'd0);
    chk("t6_async_cnt", 32'(wb_count), 32'd0);
    sb.delete();
    @(posedge clock); #1 reset = 1'b0;
    chk("t6_ready", 32'(in_ready), 32'd1);
    repeat (5) @(posedge clock); #1;
    chk("t6_no_pulse", 32'(regWrite), 32'd0);
    chk("t6_count", 32'(wb_count), 32'd0);
    chk("t6_pend", 32'(pending1), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
